// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART framing constants and the arbiter FSM state encoding.
package uart_pkg;

    localparam int   FRAME_W   = 10;
    localparam int   DATA_W    = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_e;

    // Frame bit 0 goes out first on the line, so data LSB lands at bit 1.
    function automatic logic [FRAME_W-1:0] mk_frame(input logic [DATA_W-1:0] b);
        return {STOP_BIT, b, START_BIT};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request after last_grant, wrapping.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       last_grant,
    output logic [2:0]       winner,
    output logic             valid
);

    int idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = int'(last_grant) + off;
            if (idx >= N_REQ) idx = idx - N_REQ;
            for (int i = 0; i < N_REQ; i++) begin
                if (!valid && (i == idx) && req[i]) begin
                    winner = 3'(i);
                    valid  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding single-byte frames from N_REQ requesters into one
// UART transmitter, with a confirm timeout that aborts a stuck frame.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 2_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [8*N_REQ-1:0]      req_data,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        err,
    output logic [FRAME_W-1:0]      tx_frame,
    output logic                    tx_rdy,
    input  logic                    tx_confirm,
    output logic                    busy,
    output logic [2:0]              grant_id
);

    localparam int CW = $clog2(TIMEOUT);

    state_e                        state;
    logic [CW-1:0]                 cnt;
    logic [2:0]                    last_grant;
    logic [2:0]                    winner;
    logic                          win_vld;
    logic [N_REQ-1:0][DATA_W-1:0]  data_v;
    logic [DATA_W-1:0]             sel_byte;
    logic [N_REQ-1:0]              gid_oh;

    assign data_v = req_data;
    assign busy   = (state != IDLE);

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req        (req),
        .last_grant (last_grant),
        .winner     (winner),
        .valid      (win_vld)
    );

    always_comb begin
        sel_byte = '0;
        gid_oh   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == 3'(i)) begin
                sel_byte  = data_v[i];
                gid_oh[i] = 1'b1;
            end
        end
    end

    // ack/err are registered on the leaving edge of SEND so each shows for
    // exactly the following cycle (DONE for ack, IDLE for err).
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx_rdy     <= 1'b0;
            tx_frame   <= '1;
            ack        <= '0;
            err        <= '0;
            grant_id   <= '0;
            last_grant <= 3'(N_REQ - 1);
            cnt        <= '0;
        end else begin
            ack <= '0;
            err <= '0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant_id <= winner;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    tx_frame <= mk_frame(sel_byte);
                    tx_rdy   <= 1'b1;
                    cnt      <= '0;
                    state    <= SEND;
                end
                SEND: begin
                    // Confirm is checked first so it wins over a same-cycle timeout.
                    if (tx_confirm) begin
                        tx_rdy     <= 1'b0;
                        cnt        <= '0;
                        ack        <= gid_oh;
                        last_grant <= grant_id;
                        state      <= DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        tx_rdy     <= 1'b0;
                        cnt        <= '0;
                        err        <= gid_oh;
                        last_grant <= grant_id;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: dut_a uses the default timeout, dut_t uses TIMEOUT=16.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        tx_confirm;

    logic [3:0]  ack_a, err_a, ack_t, err_t;
    logic [9:0]  frame_a, frame_t;
    logic        rdy_a, rdy_t, busy_a, busy_t;
    logic [2:0]  gid_a, gid_t;

    int n_chk = 0;
    int n_err = 0;
    int n;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(4)) dut_a (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .ack(ack_a), .err(err_a), .tx_frame(frame_a), .tx_rdy(rdy_a),
        .tx_confirm(tx_confirm), .busy(busy_a), .grant_id(gid_a)
    );

    uart_tx_arbiter #(.N_REQ(4), .TIMEOUT(16)) dut_t (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .ack(ack_t), .err(err_t), .tx_frame(frame_t), .tx_rdy(rdy_t),
        .tx_confirm(tx_confirm), .busy(busy_t), .grant_id(gid_t)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [9:0] mkf(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    task automatic wait_rdy(input bit sel_t, output int cyc);
        cyc = 0;
        while (((sel_t ? rdy_t : rdy_a) == 1'b0) && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("rdy_seen", 32'(sel_t ? rdy_t : rdy_a), 32'd1);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic confirm();
        tx_confirm = 1'b1;
        tick();
        tx_confirm = 1'b0;
    endtask

    int exp_g[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst = 1'b1; req = '0; req_data = '0; tx_confirm = 1'b0;
        repeat (3) tick();

        // Reset values
        chk("rst_rdy",   32'(rdy_a),   32'd0);
        chk("rst_frame", 32'(frame_a), 32'h3FF);
        chk("rst_ack",   32'(ack_a),   32'd0);
        chk("rst_err",   32'(err_a),   32'd0);
        chk("rst_busy",  32'(busy_a),  32'd0);
        chk("rst_gid",   32'(gid_a),   32'd0);
        rst = 1'b0;

        // Single requester 0, byte A5, confirm 20 cycles after tx_rdy
        req = 4'b0001; req_data[7:0] = 8'hA5;
        wait_rdy(1'b0, n);
        chk("single_lat",   32'(n),       32'd2);
        chk("single_frame", 32'(frame_a), 32'(10'b1_10100101_0));
        repeat (19) tick();
        chk("single_hold",  32'(rdy_a),   32'd1);
        confirm();
        req = '0;
        chk("single_ack",   32'(ack_a),   32'd1);
        chk("single_rdy0",  32'(rdy_a),   32'd0);
        tick();
        chk("single_ack1c", 32'(ack_a),   32'd0);
        chk("single_idle",  32'(busy_a),  32'd0);

        // All four requesting continuously: 0,1,2,3,0
        pulse_rst();
        req = 4'hF; req_data = 32'h44332211;
        for (int k = 0; k < 5; k++) begin
            wait_rdy(1'b0, n);
            if (k == 0) chk("rr_lat", 32'(n), 32'd2);
            else        chk("rr_gap", 32'(n), 32'd3);
            chk("rr_gid",   32'(gid_a),   32'(exp_g[k]));
            chk("rr_frame", 32'(frame_a), 32'(mkf(req_data[8*exp_g[k] +: 8])));
            confirm();
            chk("rr_ack", 32'(ack_a), 32'(1 << exp_g[k]));
        end
        req = '0;
        tick();

        // Reset during SEND aborts silently; requester 0 wins afterwards
        pulse_rst();
        req = 4'b0010;
        wait_rdy(1'b0, n);
        chk("rs_gid1", 32'(gid_a), 32'd1);
        rst = 1'b1; req = 4'b0011;
        tick();
        chk("rs_rdy",   32'(rdy_a),   32'd0);
        chk("rs_frame", 32'(frame_a), 32'h3FF);
        chk("rs_ack",   32'(ack_a),   32'd0);
        chk("rs_err",   32'(err_a),   32'd0);
        rst = 1'b0;
        tick();
        chk("rs_gid0", 32'(gid_a),  32'd0);
        chk("rs_busy", 32'(busy_a), 32'd1);
        wait_rdy(1'b0, n);
        confirm();
        chk("rs_ack0", 32'(ack_a), 32'd1);
        req = '0;
        tick();

        // Spurious confirm in IDLE; request and data dropped mid-SEND
        confirm();
        chk("sp_busy", 32'(busy_a), 32'd0);
        chk("sp_ack",  32'(ack_a),  32'd0);
        req = 4'b0100; req_data[23:16] = 8'h5A;
        wait_rdy(1'b0, n);
        chk("dr_gid", 32'(gid_a), 32'd2);
        req = '0; req_data[23:16] = 8'hFF;
        repeat (3) tick();
        chk("dr_rdy",   32'(rdy_a),   32'd1);
        chk("dr_frame", 32'(frame_a), 32'(mkf(8'h5A)));
        confirm();
        chk("dr_ack", 32'(ack_a), 32'b0100);
        chk("dr_err", 32'(err_a), 32'd0);
        tick();

        // Timeout (TIMEOUT=16): err at SEND cycle 16, next requester granted
        pulse_rst();
        req = 4'b0011; req_data[15:0] = 16'h7733;
        wait_rdy(1'b1, n);
        chk("to_gid0", 32'(gid_t), 32'd0);
        n = 0;
        while (err_t == '0 && n < 100) begin
            tick();
            n++;
        end
        chk("to_cycles", 32'(n),     32'd16);
        chk("to_err",    32'(err_t), 32'b0001);
        chk("to_rdy",    32'(rdy_t), 32'd0);
        chk("to_ack",    32'(ack_t), 32'd0);
        req = 4'b0010;
        tick();
        chk("to_gid1", 32'(gid_t),  32'd1);
        chk("to_busy", 32'(busy_t), 32'd1);
        wait_rdy(1'b1, n);
        chk("to_frame1", 32'(frame_t), 32'(mkf(8'h77)));
        confirm();
        chk("to_ack1", 32'(ack_t), 32'b0010);
        req = '0;
        tick();

        // Confirm on the last timeout cycle wins
        req = 4'b0100;
        wait_rdy(1'b1, n);
        repeat (15) tick();
        chk("last_rdy", 32'(rdy_t), 32'd1);
        confirm();
        req = '0;
        chk("last_ack", 32'(ack_t), 32'b0100);
        chk("last_err", 32'(err_t), 32'd0);
        tick();
        chk("last_ack1c", 32'(ack_t), 32'd0);
        chk("last_err1c", 32'(err_t), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
